if_stage: RTL

// - Instruction-fetch stage directly downstream of the PC register. Takes the current PC,

---
 rtl/if_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one req/gnt/rvalid fetch at a time from pc_in and
// presents results in the IF/ID register, with one skid entry for decode back-pressure.
//
// state  | meaning
// S_IDLE | no fetch outstanding; issue from pc_in once the skid is empty
// S_REQ  | imem_req held with a fixed imem_addr until imem_gnt
// S_WAIT | granted, waiting for the single imem_rvalid
module if_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        drop_q, drop_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        capture;

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = addr_q;
  assign if_id_valid = valid_q;
  assign if_id_pc    = pc_q;
  assign if_id_instr = instr_q;

  // The PC only advances on the grant of a live fetch; a flush always frees it for pc_sel.
  assign pc_stall = rst ? 1'b1 : !(flush | (imem_req & imem_gnt & !drop_q));

  assign capture = (state_q == S_WAIT) & imem_rvalid & !drop_q & !flush;

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (flush) begin
      valid_d      = 1'b0;
      instr_d      = NOP_INSTR;
      skid_valid_d = 1'b0;
    end else if (capture) begin
      if (!valid_q || !stall) begin
        valid_d = 1'b1;
        pc_d    = addr_q;
        instr_d = imem_rdata;
      end else begin
        skid_valid_d = 1'b1;
        skid_pc_d    = addr_q;
        skid_instr_d = imem_rdata;
      end
    end else if (valid_q && !stall) begin
      if (skid_valid_q) begin
        pc_d         = skid_pc_q;
        instr_d      = skid_instr_q;
        skid_valid_d = 1'b0;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drop_d  = drop_q;

    case (state_q)
      S_IDLE: begin
        // During a flush pc_in is still the old path; issue one cycle later from the target.
        if (!skid_valid_q && !flush) begin
          state_d = S_REQ;
          addr_d  = pc_in;
          drop_d  = 1'b0;
        end
      end
      S_REQ: begin
        if (flush) drop_d = 1'b1;
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          drop_d = 1'b0;
          if (flush) begin
            state_d = S_IDLE;
          end else if (!skid_valid_d) begin
            state_d = S_REQ;
            addr_d  = pc_in;
          end else begin
            state_d = S_IDLE;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= 32'd0;
      drop_q       <= 1'b0;
      valid_q      <= 1'b0;
      pc_q         <= 32'd0;
      instr_q      <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      drop_q       <= drop_d;
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

endmodule
